sum_n_sched: RTL
================

# sum_n_sched

Sequential sum-of-first-N engine with two-requester round-robin scheduling. It computes S = 1+2+…+N iteratively, one addition per clock, and shares a single accumulator datapath between two independent requesters. It is the clocked, shareable counterpart of the combinational sum-of-N block and sits between requesting control logic and any consumer of the result.

## Interface
Parameters:
- NW, 4, width of the N operand
- SW, 7, width of the sum; must satisfy SW ≥ 2·NW−1 so the maximum sum (2^NW−1)·2^NW/2 fits without overflow

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  rising-edge clock; all state updates on this edge
- rst_n  in  1  synchronous active-low reset, sampled on clk
- req0  in  1  requester 0 job request; held high until ack0
- n0  in  NW  requester 0 operand; sampled only at grant
- req1  in  1  requester 1 job request; held high until ack1
- n1  in  NW  requester 1 operand; sampled only at grant
- busy  out  1  high while accumulating (ACC state)
- done  out  1  one-cycle pulse; sum valid
- grant_id  out  1  id of current/most recent granted requester
- sum  out  SW  result; updated on done, held until next done
- ack0  out  1  one-cycle pulse coincident with done when grant_id=0
- ack1  out  1  one-cycle pulse coincident with done when grant_id=1

## Operation
- FSM states: IDLE, ACC, DONE.
- IDLE: if any req sampled high, grant, capture n of winner into cnt, clear acc, latch grant_id, go to ACC. Else stay.
- Arbitration: single request → granted. Both high → grant requester ≠ last_gnt. last_gnt resets to 1, so req0 wins the first tie. last_gnt updates at each grant.
- ACC: if cnt==0, go to DONE; else acc ← acc+cnt, cnt ← cnt−1. Sum is computed at SW bits, zero-extending cnt. No overflow is possible under the parameter rule.
- DONE: sum ← acc, done=1, ack_<grant_id>=1 for exactly one cycle, then go to IDLE.
- Requests arriving while in ACC/DONE wait. They are not lost, because the protocol requires req to stay held.
- Operand changes after capture are ignored.
- A req dropped before ack is a protocol violation. The job still completes and ack still pulses.
- Reset values: busy=0, done=0, ack0=0, ack1=0, sum=0, grant_id=0, state=IDLE, acc=0, cnt=0, last_gnt=1.
- Reset mid-operation: the job is abandoned, no ack is issued, and all outputs take their reset values on the next edge. A still-held req is re-served from scratch after release.

## Timing
- Capture edge E0 (IDLE, req high). busy high from E0 through E(n+1). done/ack high in the cycle after edge E(n+1), i.e. n+1 clocks after capture. State returns to IDLE at E(n+2).
- n=0: done one clock after capture, sum=0.
- Requester drops req on the edge after seeing ack. Earliest next capture is E(n+3), so the job period is n+3 cycles.
- sum changes only on the edge that raises done and is stable for the whole done cycle and afterwards.
- No combinational paths from inputs to outputs; all outputs are registered.

## Test plan
- Reset: hold rst_n=0 for 3 edges with random req/n → busy, done, ack0, ack1, sum, grant_id all 0. First tie afterwards grants req0.
- Single job: req0=1, n0=5 → busy for 6 cycles. Then done=ack0=1 for one cycle with sum=15, grant_id=0, ack1=0.
- Boundaries: n1=0 → done one clock after capture, sum=0, ack1. n0=15 → done 16 clocks after capture, sum=120 (no overflow in 7 bits).
- Round-robin: req0 (n0=3) and req1 (n1=4) held continuously, re-raised after each ack → grant sequence 0,1,0,1 with sums 6,10,6,10. Period per job is n+3 cycles.
- Reset mid-job: req0, n0=10, drive rst_n=0 during the 3rd ACC cycle → outputs 0 next edge, no ack0. Release with req0 still high → fresh job, sum=55 after 11 cycles.
- Operand stability: req1, n1=6, change n1 to 2 one cycle after capture → sum=21. Pending req0 raised mid-job is served next with its own n0.

Source files
------------

// File: rtl/sum_n_sched.sv
// ---------------------------------------------------------------------------
// sum_n_sched
//   Sequential sum-of-first-N engine shared between two requesters.
//   A granted job computes S = 1 + 2 + ... + N, one addition per clock, on a
//   single accumulator. Simultaneous requests are served round-robin.
//
// Ports
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset
//   req0/n0   requester 0 request (held until ack0) and operand
//   req1/n1   requester 1 request (held until ack1) and operand
//   busy      high while accumulating
//   done      one-cycle pulse, sum valid
//   grant_id  id of the current / most recently granted requester
//   sum       result, updated with done and held until the next done
//   ack0/ack1 one-cycle pulse coincident with done for the granted requester
//
// State table
//   state | meaning
//   IDLE  | waiting for a request; grants and captures the operand
//   ACC   | adds cnt into acc and counts cnt down to zero
//   DONE  | result presented (done/ack high this cycle), back to IDLE
//
// All outputs are registers. Their next values are formed in the same
// combinational block as the next state, so busy/done/ack line up exactly
// with the state they describe without any input-to-output path.
// ---------------------------------------------------------------------------
module sum_n_sched #(
    parameter int NW = 4,
    parameter int SW = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic [NW-1:0] n0,
    input  logic          req1,
    input  logic [NW-1:0] n1,
    output logic          busy,
    output logic          done,
    output logic          grant_id,
    output logic [SW-1:0] sum,
    output logic          ack0,
    output logic          ack1
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state, state_nx;
    logic [NW-1:0] cnt, cnt_nx;
    logic [SW-1:0] acc, acc_nx;
    logic          last_gnt, last_gnt_nx;
    logic          grant_id_nx;
    logic [SW-1:0] sum_nx;
    logic          busy_nx;
    logic          done_nx;
    logic          ack0_nx;
    logic          ack1_nx;
    logic          pick;

    // On a tie the requester that was not granted last time wins; a lone
    // request always wins. last_gnt resets to 1 so req0 wins the first tie.
    assign pick = (req0 && req1) ? ~last_gnt : req1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            acc      <= '0;
            last_gnt <= 1'b1;
            grant_id <= 1'b0;
            sum      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            acc      <= acc_nx;
            last_gnt <= last_gnt_nx;
            grant_id <= grant_id_nx;
            sum      <= sum_nx;
            busy     <= busy_nx;
            done     <= done_nx;
            ack0     <= ack0_nx;
            ack1     <= ack1_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        acc_nx      = acc;
        last_gnt_nx = last_gnt;
        grant_id_nx = grant_id;
        sum_nx      = sum;
        busy_nx     = 1'b0;
        done_nx     = 1'b0;
        ack0_nx     = 1'b0;
        ack1_nx     = 1'b0;

        unique case (state)
            IDLE: begin
                if (req0 || req1) begin
                    grant_id_nx = pick;
                    last_gnt_nx = pick;
                    cnt_nx      = pick ? n1 : n0;
                    acc_nx      = '0;
                    busy_nx     = 1'b1;
                    state_nx    = ACC;
                end
            end
            ACC: begin
                if (cnt == '0) begin
                    // Result registers load on the same edge that raises done,
                    // so sum is stable for the whole done cycle.
                    sum_nx   = acc;
                    done_nx  = 1'b1;
                    ack0_nx  = ~grant_id;
                    ack1_nx  = grant_id;
                    state_nx = DONE;
                end else begin
                    // SW >= 2*NW-1 guarantees the running sum never wraps.
                    acc_nx  = acc + SW'(cnt);
                    cnt_nx  = cnt - NW'(1);
                    busy_nx = 1'b1;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule
